// File: rtl/gen_sched_pkg.sv
// Shared types and constants for the packet-generator scheduler.
// Metadata layout: [15:14] src, [13:12] dst, [11:0] length in 32-byte blocks.
package gen_sched_pkg;

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_e;

  localparam int SRC_MSB = 15;
  localparam int SRC_LSB = 14;
  localparam int DST_MSB = 13;
  localparam int DST_LSB = 12;
  localparam int LEN_MSB = 11;
  localparam int LEN_LSB = 0;
  localparam int LEN_FW  = LEN_MSB - LEN_LSB + 1;

  localparam int MAX_BLOCKS = 64;
  localparam int CNT_W      = 10;
  // Legal lengths 1..64 fit in 7 bits, so the shadow queues store only that much.
  localparam int LEN_W      = 7;

  function automatic logic len_legal(input logic [LEN_FW-1:0] len);
    return (len != '0) && (len <= LEN_FW'(MAX_BLOCKS));
  endfunction

endpackage

// File: rtl/gen_sched_len_fifo.sv
// Shadow length queue for one generator: synchronous FIFO of block counts.
// Push is ignored when full; pop is ignored when empty; both may coincide.
module len_fifo
  import gen_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [LEN_W-1:0] data_i,
  output logic [LEN_W-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= bump(wr_q);
      if (do_pop)  rd_q <= bump(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/gen_sched.sv
// Steers host metadata writes to per-port generators and round-robin grants
// the shared output slot to one generator for one whole packet at a time.
module gen_sched
  import gen_sched_pkg::*;
#(
  parameter  int NPORTS          = 4,
  parameter  int QDEPTH          = 16,
  parameter  int META_WIDTH      = 16,
  parameter  int HDR_WORDS       = 7,
  parameter  int WORDS_PER_BLOCK = 8,
  localparam int PW              = $clog2(NPORTS),
  localparam int PCW             = $clog2(QDEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  meta_valid,
  input  logic [PW-1:0]         meta_port,
  input  logic [META_WIDTH-1:0] meta_in,
  output logic                  meta_ready,
  output logic [NPORTS-1:0]     meta_en,
  output logic [META_WIDTH-1:0] meta_out,
  output logic                  err_drop,
  input  logic                  sched_en,
  input  logic                  out_ready,
  output logic [NPORTS-1:0]     send_en,
  output logic [PW-1:0]         grant_port,
  output logic                  busy,
  output logic                  pkt_start,
  output logic                  pkt_end,
  output logic [NPORTS*PCW-1:0] pend_cnt
);

  state_e                state_q, state_d;
  logic [PW-1:0]         grant_q, rr_q, pick_idx, grant_next;
  logic [CNT_W-1:0]      wcnt_q;
  logic                  started_q, err_q;
  logic [NPORTS-1:0]     meta_en_q;
  logic [META_WIDTH-1:0] meta_out_q;
  logic [NPORTS-1:0]     push, pop, full, empty;
  logic [LEN_W-1:0]      head  [NPORTS];
  logic [PCW-1:0]        count [NPORTS];
  logic                  accept, legal, fire, last_send, pick_found;

  // First requester at or after ptr, wrapping; scanning downward lets the
  // smallest offset win without an early exit.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                          input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NPORTS;
      if (req[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  assign meta_ready = !full[meta_port];
  assign accept     = meta_valid && meta_ready;
  assign legal      = len_legal(meta_in[LEN_MSB:LEN_LSB]);
  assign {pick_found, pick_idx} = rr_pick(~empty, rr_q);
  assign grant_next = (grant_q == PW'(NPORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    push = '0;
    if (accept && legal) push[meta_port] = 1'b1;
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    len_fifo #(.DEPTH(QDEPTH), .CW(PCW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[p]),
      .pop_i   (pop[p]),
      .data_i  (meta_in[LEN_LSB +: LEN_W]),
      .head_o  (head[p]),
      .count_o (count[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );
    assign pend_cnt[p*PCW +: PCW] = count[p];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sched_en && (~empty != '0)) state_d = ARB;
      ARB:  state_d = pick_found ? SEND : IDLE;
      SEND: if (last_send) state_d = (sched_en && (~empty != '0)) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send_en   = '0;
    pop       = '0;
    busy      = (state_q == SEND);
    fire      = busy && out_ready;
    last_send = fire && (wcnt_q == CNT_W'(1));
    if (busy) send_en[grant_q] = out_ready;
    pop[grant_q] = last_send;
    pkt_start = fire && !started_q;
    pkt_end   = last_send;
  end

  // Word counter is loaded only in ARB, so host writes never disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= '0;
      rr_q       <= '0;
      wcnt_q     <= '0;
      started_q  <= 1'b0;
      meta_en_q  <= '0;
      meta_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      meta_en_q <= push;
      err_q     <= accept && !legal;
      if (accept && legal) meta_out_q <= meta_in;
      if (state_q == ARB && pick_found) begin
        grant_q   <= pick_idx;
        wcnt_q    <= CNT_W'(HDR_WORDS + int'(head[pick_idx]) * WORDS_PER_BLOCK);
        started_q <= 1'b0;
      end
      if (fire) begin
        wcnt_q    <= wcnt_q - 1'b1;
        started_q <= 1'b1;
      end
      if (last_send) rr_q <= grant_next;
    end
  end

  assign grant_port = grant_q;
  assign meta_en    = meta_en_q;
  assign meta_out   = meta_out_q;
  assign err_drop   = err_q;

endmodule

// File: tb/tb_gen_sched.sv
// Directed bench for gen_sched: reset, single packet, round-robin order,
// stalls, queue-full back-pressure, illegal lengths and mid-packet reset.
module tb_gen_sched;

  logic        clk = 1'b0;
  logic        reset, meta_valid, sched_en, out_ready;
  logic [1:0]  meta_port;
  logic [15:0] meta_in;
  logic        meta_ready, err_drop, busy, pkt_start, pkt_end;
  logic [3:0]  meta_en, send_en;
  logic [15:0] meta_out;
  logic [1:0]  grant_port;
  logic [19:0] pend_cnt;

  int checks = 0;
  int errors = 0;

  gen_sched dut (
    .clk        (clk),
    .reset      (reset),
    .meta_valid (meta_valid),
    .meta_port  (meta_port),
    .meta_in    (meta_in),
    .meta_ready (meta_ready),
    .meta_en    (meta_en),
    .meta_out   (meta_out),
    .err_drop   (err_drop),
    .sched_en   (sched_en),
    .out_ready  (out_ready),
    .send_en    (send_en),
    .grant_port (grant_port),
    .busy       (busy),
    .pkt_start  (pkt_start),
    .pkt_end    (pkt_end),
    .pend_cnt   (pend_cnt)
  );

  always #5 clk = ~clk;

  // Hard stop so a wedged design still produces a verdict.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [4:0] pendOf(input int p);
    return pend_cnt[p*5 +: 5];
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; meta_valid = 1'b0; meta_port = '0; meta_in = '0;
    sched_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Returns at negedge+1 just after the accepting clock edge.
  task automatic writeMeta(input logic [1:0] port, input logic [15:0] word);
    @(negedge clk);
    meta_valid = 1'b1; meta_port = port; meta_in = word;
    @(negedge clk);
    meta_valid = 1'b0;
    #1;
  endtask

  // Observes one packet, sampling each cycle before its active edge.
  task automatic collectPacket(input bit toggle, output int port, output int sends,
                               output int span, output int startPos, output int endPos,
                               output int stray, output bit timeout);
    int  first;
    bit  seen, done;
    port = -1; sends = 0; span = 0; startPos = -1; endPos = -1; stray = 0;
    first = 0; seen = 0; done = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      out_ready = toggle ? ((cyc == 0) ? 1'b1 : ~out_ready) : 1'b1;
      #1;
      if (!$onehot0(send_en)) stray++;
      if (pkt_start && send_en == '0) stray++;
      if (send_en != '0) begin
        if (!seen) begin
          seen = 1;
          first = cyc;
          for (int b = 0; b < 4; b++) if (send_en[b]) port = b;
        end else if (send_en != (4'b0001 << port)) begin
          stray++;
        end
        sends++;
        if (pkt_start) startPos = sends;
        if (pkt_end) begin
          endPos = sends;
          span = cyc - first + 1;
          done = 1;
        end
      end
    end
    timeout = !done;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (send_en !== 4'b0 || busy !== 1'b0 || pkt_start !== 1'b0 || pkt_end !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_send: send_en=%b busy=%b start=%b end=%b expected all 0", send_en, busy, pkt_start, pkt_end); end
    checks++; if (meta_en !== 4'b0 || meta_out !== 16'h0 || err_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_meta: meta_en=%b meta_out=%h err=%b expected 0", meta_en, meta_out, err_drop); end
    checks++; if (pend_cnt !== 20'h0 || grant_port !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_pend: pend=%h grant=%0d expected 0", pend_cnt, grant_port); end
  endtask

  task automatic test_single();
    int port, sends, span, sPos, ePos, stray; bit tmo;
    sched_en = 1'b1;
    writeMeta(2'd2, 16'h6001);
    checks++; if (meta_en !== 4'b0100 || meta_out !== 16'h6001) begin
      errors++; $display("[TB] FAIL single_meta: meta_en=%b meta_out=%h expected 0100 6001", meta_en, meta_out); end
    checks++; if (pendOf(2) !== 5'd1) begin
      errors++; $display("[TB] FAIL single_pend_up: got %0d expected 1", pendOf(2)); end
    collectPacket(0, port, sends, span, sPos, ePos, stray, tmo);
    checks++; if (tmo || port != 2 || sends != 15 || span != 15) begin
      errors++; $display("[TB] FAIL single_pkt: timeout=%0d port=%0d sends=%0d span=%0d expected 0 2 15 15", tmo, port, sends, span); end
    checks++; if (sPos != 1 || ePos != 15 || stray != 0) begin
      errors++; $display("[TB] FAIL single_pulses: start=%0d end=%0d stray=%0d expected 1 15 0", sPos, ePos, stray); end
    @(negedge clk); #1;
    checks++; if (pendOf(2) !== 5'd0) begin
      errors++; $display("[TB] FAIL single_pend_down: got %0d expected 0", pendOf(2)); end
  endtask

  task automatic test_round_robin();
    int port, sends, span, sPos, ePos, stray; bit tmo;
    applyReset();
    for (int p = 0; p < 4; p++) writeMeta(2'(p), 16'h0002);
    checks++; if (pend_cnt !== 20'h08421) begin
      errors++; $display("[TB] FAIL rr_pend: got %h expected 08421", pend_cnt); end
    sched_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      collectPacket(0, port, sends, span, sPos, ePos, stray, tmo);
      checks++; if (tmo || port != k || sends != 23 || stray != 0) begin
        errors++; $display("[TB] FAIL rr_grant%0d: timeout=%0d port=%0d sends=%0d stray=%0d expected 0 %0d 23 0", k, tmo, port, sends, stray, k); end
    end
  endtask

  task automatic test_stall();
    int port, sends, span, sPos, ePos, stray; bit tmo;
    writeMeta(2'd1, 16'h0004);
    collectPacket(1, port, sends, span, sPos, ePos, stray, tmo);
    checks++; if (tmo || port != 1 || sends != 39 || span != 77) begin
      errors++; $display("[TB] FAIL stall_pkt: timeout=%0d port=%0d sends=%0d span=%0d expected 0 1 39 77", tmo, port, sends, span); end
    checks++; if (sPos != 1 || ePos != 39 || stray != 0) begin
      errors++; $display("[TB] FAIL stall_pulses: start=%0d end=%0d stray=%0d expected 1 39 0", sPos, ePos, stray); end
  endtask

  task automatic test_back_to_back();
    int port, sends, span, sPos, ePos, stray; bit tmo;
    sched_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      meta_port = 2'd1; #1;
      checks++; if (meta_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL fill_ready%0d: got %b expected 1", n, meta_ready); end
      writeMeta(2'd1, 16'h0001);
    end
    @(negedge clk);
    meta_valid = 1'b1; meta_port = 2'd1; meta_in = 16'h0001; #1;
    checks++; if (meta_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_ready: got %b expected 0", meta_ready); end
    @(negedge clk);
    meta_valid = 1'b0; #1;
    checks++; if (pendOf(1) !== 5'd16 || meta_en !== 4'b0) begin
      errors++; $display("[TB] FAIL full_pend: pend=%0d meta_en=%b expected 16 0000", pendOf(1), meta_en); end
    sched_en = 1'b1;
    collectPacket(0, port, sends, span, sPos, ePos, stray, tmo);
    @(negedge clk); #1;
    checks++; if (tmo || meta_ready !== 1'b1 || pendOf(1) !== 5'd15) begin
      errors++; $display("[TB] FAIL drain_ready: timeout=%0d ready=%b pend=%0d expected 0 1 15", tmo, meta_ready, pendOf(1)); end
    sched_en = 1'b0;
  endtask

  task automatic test_illegal_len();
    writeMeta(2'd0, 16'h0000);
    checks++; if (err_drop !== 1'b1 || meta_en !== 4'b0 || pendOf(0) !== 5'd0) begin
      errors++; $display("[TB] FAIL len0: err=%b meta_en=%b pend=%0d expected 1 0000 0", err_drop, meta_en, pendOf(0)); end
    writeMeta(2'd0, 16'h0041);
    checks++; if (err_drop !== 1'b1 || meta_en !== 4'b0 || pendOf(0) !== 5'd0) begin
      errors++; $display("[TB] FAIL len65: err=%b meta_en=%b pend=%0d expected 1 0000 0", err_drop, meta_en, pendOf(0)); end
    writeMeta(2'd0, 16'hF040);
    checks++; if (err_drop !== 1'b0 || meta_en !== 4'b0001 || meta_out !== 16'hF040 || pendOf(0) !== 5'd1) begin
      errors++; $display("[TB] FAIL len64: err=%b meta_en=%b out=%h pend=%0d expected 0 0001 f040 1", err_drop, meta_en, meta_out, pendOf(0)); end
  endtask

  task automatic test_reset_mid_packet();
    int port, sends, span, sPos, ePos, stray, n; bit tmo;
    applyReset();
    writeMeta(2'd2, 16'h0001);
    writeMeta(2'd3, 16'h0040);
    sched_en = 1'b1;
    collectPacket(0, port, sends, span, sPos, ePos, stray, tmo);
    checks++; if (tmo || port != 2) begin
      errors++; $display("[TB] FAIL mid_first: timeout=%0d port=%0d expected 0 2", tmo, port); end
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      @(negedge clk); #1;
      if (send_en == 4'b1000) n++;
    end
    checks++; if (n != 10) begin
      errors++; $display("[TB] FAIL mid_reach10: got %0d sends expected 10", n); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (send_en !== 4'b0 || busy !== 1'b0 || pkt_start !== 1'b0 || pkt_end !== 1'b0 || grant_port !== 2'd0) begin
      errors++; $display("[TB] FAIL mid_reset_out: send_en=%b busy=%b start=%b end=%b grant=%0d expected 0", send_en, busy, pkt_start, pkt_end, grant_port); end
    checks++; if (pend_cnt !== 20'h0 || meta_en !== 4'b0 || err_drop !== 1'b0 || meta_out !== 16'h0) begin
      errors++; $display("[TB] FAIL mid_reset_state: pend=%h meta_en=%b err=%b out=%h expected 0", pend_cnt, meta_en, err_drop, meta_out); end
    reset = 1'b0; sched_en = 1'b0;
    writeMeta(2'd3, 16'h0001);
    writeMeta(2'd0, 16'h0001);
    sched_en = 1'b1;
    collectPacket(0, port, sends, span, sPos, ePos, stray, tmo);
    checks++; if (tmo || port != 0 || sends != 15) begin
      errors++; $display("[TB] FAIL mid_priority: timeout=%0d port=%0d sends=%0d expected 0 0 15", tmo, port, sends); end
  endtask

  initial begin
    reset = 1'b1; meta_valid = 1'b0; meta_port = '0; meta_in = '0;
    sched_en = 1'b0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_back_to_back();
    test_illegal_len();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_sched.md
Name: gen_sched

Overview:
- Controller for the per-port packet generators, which hold metadata in internal queues and emit 32-bit words while their send enable is high.
- Accepts metadata writes from the host interface and steers each write to the generator of the selected port.
- Keeps a shadow length queue per port, so it knows how many packets and words each generator has pending.
- Round-robin arbitrates a shared output slot. It holds one generator's send_en for exactly one whole packet, then moves on.

Parameters:
- NPORTS, 4, number of generators (port index width = $clog2(NPORTS)).
- QDEPTH, 16, maximum pending packets per port; must not exceed the generator metadata memory depth.
- META_WIDTH, 16, metadata word: [15:14] src, [13:12] dst, [11:0] length in 32-byte blocks.
- HDR_WORDS, 7, fixed per-packet send cycles (header plus framing).
- WORDS_PER_BLOCK, 8, 32-bit words per 32-byte block.
- MAX_BLOCKS, 64, largest legal length.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- meta_valid  in  1  host metadata write request
- meta_port  in  2  target generator index
- meta_in  in  META_WIDTH  metadata word
- meta_ready  out  1  write accepted this cycle when high with meta_valid
- meta_en  out  NPORTS  one-hot write strobe to generators
- meta_out  out  META_WIDTH  registered metadata to generators
- err_drop  out  1  pulse: illegal length discarded
- sched_en  in  1  scheduler run enable
- out_ready  in  1  downstream can take a word this cycle
- send_en  out  NPORTS  one-hot advance enable to generators
- grant_port  out  2  currently granted port
- busy  out  1  a packet is in flight
- pkt_start  out  1  pulse on first send cycle of a packet
- pkt_end  out  1  pulse on last send cycle of a packet
- pend_cnt  out  NPORTS*5  per-port pending packet count, port 0 in LSBs

Behaviour:
- Reset values: all outputs 0; pend_cnt 0; RR pointer 0 (port 0 has first priority); state IDLE.
- Write acceptance:
  - meta_ready = !full[meta_port], where full means pend_cnt == QDEPTH.
  - A push is blocked when full even if a pop happens the same cycle.
- Accepted write with length 1..MAX_BLOCKS:
  - Next cycle: meta_en[meta_port] = 1 and meta_out = meta_in (latency 1).
  - Length pushed to that port's shadow queue; pend_cnt increments.
- Accepted write with length 0 or > MAX_BLOCKS:
  - Consumed without forwarding: no meta_en, no push.
  - err_drop pulses 1 cycle, latency 1.
- Packet word count = HDR_WORDS + length*WORDS_PER_BLOCK; range 15..519, held in a 10-bit counter.
- FSM:
  - IDLE: if sched_en and any pend_cnt != 0 → ARB.
  - ARB (1 cycle): pick the first non-empty port searching from rr_ptr upward with wrap. Latch grant_port, load word counter from that queue's head → SEND. If all queues are empty → IDLE.
  - SEND:
    - send_en[grant] = out_ready; no other bit is ever set.
    - busy = 1; the counter decrements on each cycle send_en is high.
    - pkt_start on the first such cycle.
    - Stalls (out_ready = 0) freeze the counter and deassert send_en.
    - On the cycle send_en is high and counter == 1: pkt_end pulses, head is popped, pend_cnt decrements, rr_ptr = grant+1 (mod NPORTS).
    - Next state: ARB if sched_en is high and any queue is non-empty, else IDLE.
- sched_en low during SEND: the current packet completes; no new grant is issued.
- Push and pop on the same port in the same cycle: pend_cnt unchanged, both take effect.
- A write to the port currently being sent never alters the in-flight counter.
- send_en is one-hot or zero in every cycle; meta_en is one-hot or zero.
- Reset mid-packet: immediate return to reset values; generators share the reset, so no partial-packet recovery is required.

Decomposition:
- Package gen_sched_pkg:
  - state enum (IDLE, ARB, SEND);
  - field positions LEN_MSB/LSB, DST_MSB/LSB, SRC_MSB/LSB;
  - constants MAX_BLOCKS and CNT_W = 10.
- Sub-module len_fifo: one per port, synchronous FIFO storing 7-bit lengths.
  - Interface: push, pop, head, count, full, empty.
  - Same-cycle push and pop are legal when not full.
- Round-robin priority pick: a function inside gen_sched.

Test Plan:
1. Reset, then write port 2 with length 1, sched_en = 1, out_ready = 1 → meta_en = 4'b0100 one cycle after the write; send_en[2] high for exactly 15 consecutive cycles; pkt_start on the first of them, pkt_end on the last; pend_cnt[2] returns to 0.
2. One length-2 packet queued on each of ports 0–3 → grants in order 0,1,2,3; each port gets 23 send cycles; send_en always one-hot.
3. Length-4 packet (39 words) with out_ready toggling 1,0 → 39 send_en cycles spread over 77 clocks; pkt_end coincides with the 39th send.
4. 16 writes to port 1 with sched_en = 0 → meta_ready low on the 17th attempt; pend_cnt[1] = 16. Raise sched_en; after the first pkt_end, meta_ready is high again.
5. Writes with length 0 and length 65 → err_drop pulses; no meta_en; pend_cnt unchanged.
6. Assert reset during cycle 10 of a length-64 packet → all outputs 0 next cycle; pend_cnt all 0; port 0 has first priority after reset.
